// File: rtl/module_gen_pulsos_if.sv
// Command handshake for the press transmitter: valid/sel/count offered by the master, ready returned.
interface module_gen_pulsos_if;
    logic       cmd_valid_pi;
    logic       cmd_sel_pi;
    logic [2:0] cmd_count_pi;
    logic       cmd_ready_po;

    modport master (
        output cmd_valid_pi,
        output cmd_sel_pi,
        output cmd_count_pi,
        input  cmd_ready_po
    );

    modport slave (
        input  cmd_valid_pi,
        input  cmd_sel_pi,
        input  cmd_count_pi,
        output cmd_ready_po
    );
endinterface

// File: rtl/module_gen_pulsos.sv
// Press transmitter: emits cmd_count presses of PULSE_CYC cycles on p1/p2, each followed by GAP_CYC low cycles.
// Optional GEN_PULSOS_ABORT_EN adds abort_pi to cut the command short through a final gap and DONE.
module module_gen_pulsos #(
    parameter int unsigned PULSE_CYC = 11,
    parameter int unsigned GAP_CYC   = 12800
) (
    input  logic                clk_pi,
    input  logic                rst_n_pi,
`ifdef GEN_PULSOS_ABORT_EN
    input  logic                abort_pi,
`endif
    module_gen_pulsos_if.slave  cmd,
    output logic                p1_po,
    output logic                p2_po,
    output logic                busy_po,
    output logic                done_po
);

    localparam int unsigned MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {IDLE, PRESS, GAP, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;
    logic [2:0]         rem_q, rem_d;
    logic               p1_q, p1_d, p2_q, p2_d;
    logic               busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic               abort;
    logic [2:0]         rem_eff;

`ifdef GEN_PULSOS_ABORT_EN
    assign abort = abort_pi;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk_pi) begin
        if (!rst_n_pi) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            rem_q   <= '0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        rem_eff = abort ? 3'd0 : rem_q;

        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid_pi) begin
                    sel_d = cmd.cmd_sel_pi;
                    rem_d = cmd.cmd_count_pi;
                    if (cmd.cmd_count_pi != 3'd0) begin
                        state_d = PRESS;
                        cnt_d   = CNT_W'(PULSE_CYC - 1);
                    end else begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end
                end
            end
            PRESS: begin
                // Counter holds cycles remaining minus one, so zero marks the last cycle of the state.
                if (abort) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                    rem_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                    rem_d   = rem_q - 3'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                rem_d = rem_eff;
                if (cnt_q == '0) begin
                    if (rem_eff != 3'd0) begin
                        state_d = PRESS;
                        cnt_d   = CNT_W'(PULSE_CYC - 1);
                    end else begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they change exactly with the state.
        p1_d    = (state_d == PRESS) && !sel_d;
        p2_d    = (state_d == PRESS) && sel_d;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        ready_d = (state_d == IDLE);
    end

    assign p1_po            = p1_q;
    assign p2_po            = p2_q;
    assign busy_po          = busy_q;
    assign done_po          = done_q;
    assign cmd.cmd_ready_po = ready_q;

endmodule

// File: tb/tb_module_gen_pulsos.sv
// Bench: default-parameter instance for the long directed sequences, small-parameter instance
// for a command table and randomized traffic against a timeline model.
module tb_module_gen_pulsos;

    localparam int PA = 11;
    localparam int GA = 12800;
    localparam int PB = 3;
    localparam int GB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic p1a, p2a, busya, donea;
    logic p1b, p2b, busyb, doneb;
`ifdef GEN_PULSOS_ABORT_EN
    logic abort_a;
`endif

    module_gen_pulsos_if ifa ();
    module_gen_pulsos_if ifb ();

    module_gen_pulsos dut_a (
        .clk_pi   (clk),
        .rst_n_pi (rst_a),
`ifdef GEN_PULSOS_ABORT_EN
        .abort_pi (abort_a),
`endif
        .cmd      (ifa.slave),
        .p1_po    (p1a),
        .p2_po    (p2a),
        .busy_po  (busya),
        .done_po  (donea)
    );

    module_gen_pulsos #(.PULSE_CYC(PB), .GAP_CYC(GB)) dut_b (
        .clk_pi   (clk),
        .rst_n_pi (rst_b),
`ifdef GEN_PULSOS_ABORT_EN
        .abort_pi (1'b0),
`endif
        .cmd      (ifb.slave),
        .p1_po    (p1b),
        .p2_po    (p2b),
        .busy_po  (busyb),
        .done_po  (doneb)
    );

    logic [4:0] obs_a, obs_b;
    assign obs_a = {p1a, p2a, busya, donea, ifa.cmd_ready_po};
    assign obs_b = {p1b, p2b, busyb, doneb, ifb.cmd_ready_po};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expected {p1,p2,busy,done,ready} in the rel-th cycle after a command (sel,n) is accepted.
    function automatic logic [4:0] model(input int rel, input bit sel, input int n,
                                         input int p, input int g);
        int  per;
        int  done_rel;
        int  k;
        bit  on;
        per      = p + g;
        done_rel = n * per + 1;
        if (rel > done_rel) return 5'b00001;
        if (rel == done_rel) return 5'b00110;
        k  = (rel - 1) % per;
        on = (k < p);
        return {on && !sel, on && sel, 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic wave_a(input string name, input bit sel, input int n, input bit poke);
        int         mism;
        int         pulses;
        int         last;
        logic       prev;
        logic       cur;
        logic [4:0] e;
        mism   = 0;
        pulses = 0;
        prev   = 1'b0;
        last   = n * (PA + GA) + 2;
        check($sformatf("%s_ready_before", name), ifa.cmd_ready_po, 1);
        ifa.cmd_valid_pi = 1'b1;
        ifa.cmd_sel_pi   = sel;
        ifa.cmd_count_pi = 3'(n);
        for (int rel = 1; rel <= last; rel++) begin
            @(negedge clk);
            if (poke && (rel == 7 || rel == PA + GA + 3)) begin
                ifa.cmd_valid_pi = 1'b1;
                ifa.cmd_sel_pi   = ~sel;
                ifa.cmd_count_pi = 3'd7;
            end else begin
                ifa.cmd_valid_pi = 1'b0;
            end
            e = model(rel, sel, n, PA, GA);
            if (obs_a !== e) mism++;
            if (rel == 1 || rel == last - 1) check($sformatf("%s_rel%0d", name, rel), obs_a, e);
            cur = sel ? p2a : p1a;
            if (cur && !prev) pulses++;
            prev = cur;
        end
        check($sformatf("%s_wave_mismatch_cycles", name), mism, 0);
        check($sformatf("%s_pulses", name), pulses, n);
    endtask

    typedef struct {
        bit sel;
        int cnt;
        int exp_pulses;
        int exp_lat;
    } vec_t;

    task automatic run_vec_b(input vec_t v, input int idx);
        int   pul;
        int   other;
        int   lat;
        logic prev;
        logic cur;
        pul   = 0;
        other = 0;
        lat   = -1;
        prev  = 1'b0;
        check($sformatf("tbl%0d_ready", idx), ifb.cmd_ready_po, 1);
        ifb.cmd_valid_pi = 1'b1;
        ifb.cmd_sel_pi   = v.sel;
        ifb.cmd_count_pi = 3'(v.cnt);
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(negedge clk);
            ifb.cmd_valid_pi = 1'b0;
            cur = v.sel ? p2b : p1b;
            if (cur && !prev) pul++;
            prev = cur;
            if (v.sel ? p1b : p2b) other++;
            if (doneb) lat = c;
        end
        check($sformatf("tbl%0d_pulses", idx), pul, v.exp_pulses);
        check($sformatf("tbl%0d_done_latency", idx), lat, v.exp_lat);
        check($sformatf("tbl%0d_other_line", idx), other, 0);
        @(negedge clk);
        check($sformatf("tbl%0d_idle_after", idx), obs_b, 5'b00001);
    endtask

    task automatic random_b(input int cycles);
        bit         active;
        int         acc;
        int         an;
        bit         asel;
        bit         v;
        bit         s;
        int         cnt;
        logic [4:0] e;
        active = 1'b0;
        acc    = 0;
        an     = 0;
        asel   = 1'b0;
        for (int cur = 0; cur < cycles; cur++) begin
            @(negedge clk);
            e = active ? model(cur - acc, asel, an, PB, GB) : 5'b00001;
            check($sformatf("rand_c%0d", cur), obs_b, e);
            v   = ($urandom_range(0, 3) == 0);
            s   = 1'($urandom_range(0, 1));
            cnt = int'($urandom_range(0, 3));
            ifb.cmd_valid_pi = v;
            ifb.cmd_sel_pi   = s;
            ifb.cmd_count_pi = 3'(cnt);
            if (v && e[0]) begin
                active = 1'b1;
                acc    = cur;
                an     = cnt;
                asel   = s;
            end
        end
        @(negedge clk);
        ifb.cmd_valid_pi = 1'b0;
    endtask

    task automatic reset_mid_press();
        int nodone;
        check("rst_mid_ready", ifa.cmd_ready_po, 1);
        ifa.cmd_valid_pi = 1'b1;
        ifa.cmd_sel_pi   = 1'b1;
        ifa.cmd_count_pi = 3'd2;
        for (int rel = 1; rel <= 5; rel++) begin
            @(negedge clk);
            ifa.cmd_valid_pi = 1'b0;
        end
        check("rst_mid_press_high", {p1a, p2a}, 2'b01);
        rst_a = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", {p1a, p2a, busya, donea}, 4'b0000);
        @(negedge clk);
        rst_a = 1'b1;
        nodone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (obs_a !== 5'b00001) nodone++;
        end
        check("rst_mid_idle_no_done", nodone, 0);
    endtask

`ifdef GEN_PULSOS_ABORT_EN
    task automatic abort_seq();
        int   trig;
        int   pulses;
        int   lat;
        logic prev;
        trig   = PA + GA + 3;
        pulses = 0;
        lat    = -1;
        prev   = 1'b0;
        ifa.cmd_valid_pi = 1'b1;
        ifa.cmd_sel_pi   = 1'b0;
        ifa.cmd_count_pi = 3'd5;
        for (int rel = 1; rel <= 3 * (PA + GA) && lat < 0; rel++) begin
            @(negedge clk);
            ifa.cmd_valid_pi = 1'b0;
            abort_a = (rel == trig);
            if (rel == trig + 1) check("abort_p_low_next", p1a, 1'b0);
            if (p1a && !prev) pulses++;
            prev = p1a;
            if (donea) lat = rel;
        end
        abort_a = 1'b0;
        check("abort_pulses", pulses, 2);
        check("abort_done_rel", lat, trig + GA + 1);
        @(negedge clk);
    endtask
`endif

    vec_t tbl [6];

    initial begin
        tbl[0] = '{sel: 1'b0, cnt: 0, exp_pulses: 0, exp_lat: 1};
        tbl[1] = '{sel: 1'b1, cnt: 0, exp_pulses: 0, exp_lat: 1};
        tbl[2] = '{sel: 1'b0, cnt: 1, exp_pulses: 1, exp_lat: 8};
        tbl[3] = '{sel: 1'b1, cnt: 2, exp_pulses: 2, exp_lat: 15};
        tbl[4] = '{sel: 1'b0, cnt: 7, exp_pulses: 7, exp_lat: 50};
        tbl[5] = '{sel: 1'b1, cnt: 5, exp_pulses: 5, exp_lat: 36};

        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.cmd_valid_pi = 1'b0;
        ifa.cmd_sel_pi   = 1'b0;
        ifa.cmd_count_pi = 3'd0;
        ifb.cmd_valid_pi = 1'b0;
        ifb.cmd_sel_pi   = 1'b0;
        ifb.cmd_count_pi = 3'd0;
`ifdef GEN_PULSOS_ABORT_EN
        abort_a = 1'b0;
`endif
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check("reset_a_outputs", obs_a, 5'b00001);
        check("reset_b_outputs", obs_b, 5'b00001);

        wave_a("p1_count1", 1'b0, 1, 1'b0);
        wave_a("p2_count3", 1'b1, 3, 1'b1);
        wave_a("count0", 1'b0, 0, 1'b0);
        reset_mid_press();
`ifdef GEN_PULSOS_ABORT_EN
        abort_seq();
`endif

        for (int i = 0; i < 6; i++) run_vec_b(tbl[i], i);
        random_b(800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/module_gen_pulsos.md
MODULE_GEN_PULSOS -- requirements
Module: module_gen_pulsos

Interface
REQ-001 Parameter PULSE_CYC, default 11: press width in clk_pi cycles (110 ns at 100 MHz); legal range >= 1.
REQ-002 Parameter GAP_CYC, default 12800: mandatory low time after every press in cycles (128 us at 100 MHz); legal range >= 1.
REQ-003 clk_pi  input  1  sole clock, 100 MHz; all logic rising-edge.
REQ-004 rst_n_pi  input  1  reset, synchronous and active-low.
REQ-005 cmd_valid_pi  input  1  command offered this cycle.
REQ-006 cmd_sel_pi  input  1  target button: 0 = p1, 1 = p2.
REQ-007 cmd_count_pi  input  3  number of presses to emit, 0..7.
REQ-008 cmd_ready_po  output  1  block can accept a command this cycle.
REQ-009 p1_po  output  1  press drive toward the p1_pi input of the light controller.
REQ-010 p2_po  output  1  press drive toward the p2_pi input of the light controller.
REQ-011 busy_po  output  1  high while any command is in progress.
REQ-012 done_po  output  1  one-cycle pulse when a command completes.

Function
REQ-013 The block SHALL be the press transmitter for the light controller: each command generates cmd_count_pi clean, debounce-compatible presses on the selected line.
REQ-014 FSM states SHALL be IDLE, PRESS, GAP and DONE.
REQ-015 cmd_ready_po SHALL equal 1 exactly in IDLE; a command is accepted on a rising edge where cmd_valid_pi and cmd_ready_po are both 1.
REQ-016 On acceptance, sel and count SHALL be latched; later input changes SHALL have no effect until the next acceptance.
REQ-017 Accepted count > 0: IDLE->PRESS; the selected output SHALL rise in the first cycle after acceptance and stay high exactly PULSE_CYC cycles.
REQ-018 PRESS->GAP after PULSE_CYC cycles; both p outputs SHALL be low for exactly GAP_CYC cycles; the remaining count decrements on GAP entry.
REQ-019 GAP end: remaining > 0 -> PRESS; remaining = 0 -> DONE.
REQ-020 DONE SHALL last one cycle with done_po=1, then -> IDLE.
REQ-021 Accepted count = 0: IDLE->DONE directly; no press is emitted; done_po asserts in the cycle after acceptance.
REQ-022 The unselected p output SHALL stay 0; p1_po and p2_po SHALL never both be 1.
REQ-023 busy_po SHALL be 1 in PRESS, GAP and DONE, and 0 in IDLE.
REQ-024 The trailing GAP SHALL guarantee >= GAP_CYC low cycles between the last press of one command and the first press of the next.
REQ-025 The cycle counter width SHALL be sized from max(PULSE_CYC, GAP_CYC) with no wrap-around; the counter reloads on every state entry.
REQ-026 All outputs SHALL be registered (glitch-free).

Reset
REQ-027 When rst_n_pi=0 at a rising edge: state=IDLE, counters=0, latched sel/count=0, p1_po=p2_po=0, busy_po=0, done_po=0, cmd_ready_po=1 from the first cycle after release.
REQ-028 Reset SHALL take effect in any state, including mid-press; the press is truncated and the command is discarded without a done_po pulse.

Configuration
REQ-029 Macro GEN_PULSOS_ABORT_EN: when defined, add input abort_pi (1 bit); abort_pi=1 in PRESS forces p outputs low in the next cycle, zeroes the remaining count and enters GAP; in GAP it zeroes the remaining count; the command still ends via a full GAP and DONE; ignored in IDLE/DONE.
REQ-030 Without GEN_PULSOS_ABORT_EN, the abort_pi port and its logic SHALL not exist, and behaviour SHALL be as REQ-013..REQ-028.

Verification (defaults PULSE_CYC=11, GAP_CYC=12800)
REQ-031 Reset held 5 cycles, then released -> all outputs 0 except cmd_ready_po=1.
REQ-032 sel=0, count=1 accepted at edge E -> p1_po high in cycles E+1..E+11, low for 12800 cycles, done_po=1 in cycle E+12812, p2_po constant 0.
REQ-033 sel=1, count=3 -> exactly 3 p2_po pulses of 11 cycles with 12800-cycle gaps; done_po one cycle after the 3rd gap; cmd_ready_po=0 throughout; inputs changed mid-command are ignored.
REQ-034 count=0 accepted -> no press; done_po in the next cycle; back to IDLE.
REQ-035 rst_n_pi=0 on cycle 5 of a press -> p outputs 0 in the next cycle, no done_po, IDLE after release.
REQ-036 With GEN_PULSOS_ABORT_EN: abort_pi pulsed during the 2nd press of count=5 -> press truncated, one full 12800-cycle gap, done_po, total of 2 pulses.
